// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
//   Shared definitions for the memory access path: uOP encodings, data address
//   map constants and the address region type. Also used by the register-return
//   mux.
// -----------------------------------------------------------------------------
package cpu_pkg;

   // Data address map
   localparam int unsigned DC_WORDS   = 31;   // D-cache word addresses 0..DC_WORDS-1
   localparam int unsigned GPIO_ADDR  = 32;   // single GPIO word address
   localparam int unsigned DC_TIMEOUT = 15;   // max cycles waiting for dc_ack

   typedef enum logic [4:0] {
      UOP_LDR = 5'd10,
      UOP_STR = 5'd11
   } uop_e;

   typedef enum logic [1:0] {
      DC,
      GPIO,
      UNMAPPED
   } addr_region_t;

endpackage

// File: rtl/mem_addr_decode.sv
// -----------------------------------------------------------------------------
// mem_addr_decode
//   Combinational data address map decode: word address -> region.
//   The full 32-bit address is compared so aliases such as 0x8000_0005 are
//   reported as unmapped rather than folded onto the D-cache.
// Ports
//   i_addr    in  32  word address
//   o_region  out  2  DC / GPIO / UNMAPPED
// -----------------------------------------------------------------------------
module mem_addr_decode
   import cpu_pkg::*;
#(
   parameter int unsigned DC_WORDS  = cpu_pkg::DC_WORDS,
   parameter int unsigned GPIO_ADDR = cpu_pkg::GPIO_ADDR
) (
   input  logic [31:0]  i_addr,
   output addr_region_t o_region
);

   always_comb begin
      o_region = UNMAPPED;
      if (i_addr < 32'(DC_WORDS)) begin
         o_region = DC;
      end else if (i_addr == 32'(GPIO_ADDR)) begin
         o_region = GPIO;
      end
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//   Sequences LDR/STR uOPs from execute onto the D-cache or the GPIO word,
//   returns load data with a one-cycle valid, stalls the pipeline while busy
//   and flags unmapped or timed-out accesses.
// Ports
//   clk, rst_n               clock (rising edge), async active-low reset
//   req_valid/req_ready      uOP handshake from execute (ready only in IDLE)
//   uop, addr, wdata         uOP code (10=LDR, 11=STR), word address, store data
//   dc_req/dc_we/dc_addr/    D-cache request, held until dc_ack
//   dc_wdata
//   dc_ack/dc_rdata          D-cache completion and load data
//   gpio_state               current GPIO input word
//   gpio_we/gpio_wdata       one-cycle GPIO output write strobe and data
//   rsp_valid/rsp_data       one-cycle load return; data holds between pulses
//   stall                    pipeline hold while not IDLE
//   err                      one-cycle pulse on unmapped address or timeout
// -----------------------------------------------------------------------------
module mem_access_ctrl
   import cpu_pkg::*;
#(
   parameter int unsigned DC_WORDS   = cpu_pkg::DC_WORDS,
   parameter int unsigned GPIO_ADDR  = cpu_pkg::GPIO_ADDR,
   parameter int unsigned DC_TIMEOUT = cpu_pkg::DC_TIMEOUT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [4:0]  uop,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        dc_req,
   output logic        dc_we,
   output logic [4:0]  dc_addr,
   output logic [31:0] dc_wdata,
   input  logic        dc_ack,
   input  logic [31:0] dc_rdata,
   input  logic [31:0] gpio_state,
   output logic        gpio_we,
   output logic [31:0] gpio_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_data,
   output logic        stall,
   output logic        err
);

   localparam int unsigned CNT_W = $clog2(DC_TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE,
      DC_WAIT,
      GPIO_ACC,
      RESP
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [4:0]         r_uop;
   logic [4:0]         r_dc_addr;
   logic [31:0]        r_wdata;
   logic [CNT_W-1:0]   r_tmo_cnt;
   logic               r_err;
   logic [31:0]        r_rsp_data;

   addr_region_t       w_region;
   logic               w_accept;
   logic               w_in_ldr;
   logic               w_in_str;
   logic               w_is_ldr;
   logic               w_is_str;
   logic               w_err_nxt;
   logic               w_rsp_we;
   logic [31:0]        w_rsp_nxt;
   logic               w_tmo_hit;

   mem_addr_decode #(
      .DC_WORDS  (DC_WORDS),
      .GPIO_ADDR (GPIO_ADDR)
   ) u_decode (
      .i_addr   (addr),
      .o_region (w_region)
   );

   assign w_accept  = req_valid && (r_state == IDLE);
   assign w_in_ldr  = (uop == UOP_LDR);
   assign w_in_str  = (uop == UOP_STR);
   assign w_is_ldr  = (r_uop == UOP_LDR);
   assign w_is_str  = (r_uop == UOP_STR);
   assign w_tmo_hit = (r_tmo_cnt == CNT_W'(DC_TIMEOUT - 1));

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state, error flag and load-result capture
   always_comb begin
      w_state_nxt = r_state;
      w_err_nxt   = 1'b0;
      w_rsp_we    = 1'b0;
      w_rsp_nxt   = '0;
      unique case (r_state)
         IDLE: begin
            if (w_accept && (w_in_ldr || w_in_str)) begin
               unique case (w_region)
                  DC:       w_state_nxt = DC_WAIT;
                  GPIO:     w_state_nxt = GPIO_ACC;
                  default: begin
                     w_state_nxt = RESP;
                     w_err_nxt   = 1'b1;
                     w_rsp_we    = w_in_ldr;
                  end
               endcase
            end
         end
         DC_WAIT: begin
            // ack takes priority over a timeout landing in the same cycle
            if (dc_ack) begin
               w_state_nxt = RESP;
               w_rsp_we    = w_is_ldr;
               w_rsp_nxt   = dc_rdata;
            end else if (w_tmo_hit) begin
               w_state_nxt = RESP;
               w_err_nxt   = 1'b1;
               w_rsp_we    = w_is_ldr;
            end
         end
         GPIO_ACC: begin
            w_state_nxt = RESP;
            w_rsp_we    = w_is_ldr;
            w_rsp_nxt   = gpio_state;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Request capture, timeout counter, response registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_uop      <= '0;
         r_dc_addr  <= '0;
         r_wdata    <= '0;
         r_tmo_cnt  <= '0;
         r_err      <= 1'b0;
         r_rsp_data <= '0;
      end else begin
         if (w_accept) begin
            r_uop     <= uop;
            r_dc_addr <= addr[4:0];
            r_wdata   <= wdata;
         end
         if ((r_state == DC_WAIT) && !dc_ack) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
         end else begin
            r_tmo_cnt <= '0;
         end
         r_err <= w_err_nxt;
         if (w_rsp_we) begin
            r_rsp_data <= w_rsp_nxt;
         end
      end
   end

   assign req_ready  = (r_state == IDLE);
   assign stall      = (r_state != IDLE);
   assign dc_req     = (r_state == DC_WAIT);
   assign dc_we      = (r_state == DC_WAIT) && w_is_str;
   assign dc_addr    = r_dc_addr;
   assign dc_wdata   = r_wdata;
   assign gpio_we    = (r_state == GPIO_ACC) && w_is_str;
   assign gpio_wdata = r_wdata;
   assign rsp_valid  = (r_state == RESP) && w_is_ldr;
   assign rsp_data   = r_rsp_data;
   assign err        = (r_state == RESP) && r_err;

endmodule
